microwave_timer_core: RTL and testbench
=======================================

Name: microwave_timer_core

Overview:
- Four-digit BCD MM:SS timer directly downstream of the keypad encoder / timer-input-control stage.
- Consumes D[3:0], loadn, pgt_1Hz and enablen.
- Programming mode: shifts keyed digits in from the right.
- Counting mode: decrements once per 1 Hz tick and flags 00:00 for the oven controller and the display decoders.

Parameters:
SEC_TENS_MAX, 5, value loaded into seconds-tens on a borrow from minutes
DIGIT_MAX, 9, value loaded into any units digit on a borrow; also the highest digit code accepted on D

Ports:
clk  input  1  system clock; all state changes on rising edge
clear  input  1  synchronous, active-high reset
enablen  input  1  mode select: 1 = programming (key entry), 0 = counting
D  input  4  encoded key digit, valid while loadn=0
loadn  input  1  active-low key-valid strobe from the encoder
pgt_1Hz  input  1  1 Hz timebase level signal (rising edge = one tick)
min_tens  output  4  BCD minutes tens
min_ones  output  4  BCD minutes units
sec_tens  output  4  BCD seconds tens
sec_ones  output  4  BCD seconds units
zero  output  1  high while all four digits are 0
done  output  1  one-cycle pulse on the count reaching 00:00 from a non-zero value

Behaviour:
- Interface: one clock, clk. Reset is synchronous, active-high, port clear.
- Reset (clear=1 at a rising clk):
  - all digits 0; zero=1; done=0.
  - loadn_q=1, pgt_q=1; the 1 Hz edge register resets high so an already-high timebase causes no spurious tick.
  - clear overrides every other input.
- Edge detection, registered every cycle regardless of mode:
  - load_ev = loadn_q & ~loadn
  - tick_ev = ~pgt_q & pgt_1Hz
- Programming (enablen=1), on load_ev with D<=DIGIT_MAX:
  - min_tens<=min_ones; min_ones<=sec_tens; sec_tens<=sec_ones; sec_ones<=D.
  - Update is visible after the same clk edge that sampled the strobe.
- Programming, D in 10..15: load_ev is ignored and digits are held.
- Programming: tick_ev is ignored.
- Held loadn=0 across many cycles produces exactly one shift.
- Counting (enablen=0), on tick_ev with zero=0, BCD decrement:
  - sec_ones>0: sec_ones-1.
  - else sec_ones<=9 and borrow into sec_tens.
  - sec_tens>0: sec_tens-1.
  - else sec_tens<=SEC_TENS_MAX and borrow into min_ones.
  - min_ones>0: min_ones-1.
  - else min_ones<=9 and min_tens-1.
  - Entered seconds-tens above 5 (e.g. 99) are counted down as entered, not normalised.
- Counting: tick_ev with zero=1 holds at 00:00; no wrap to 99:59. load_ev is ignored.
- done: asserted for exactly one cycle on the edge where the decrement produces 0000. It never asserts from loading, and never when already zero.
- zero: combinational compare of the registered digits, so it follows the digits with no extra latency.
- Mode switch mid-operation: digits are retained, and edge registers keep tracking. A loadn falling edge coincident with the switch to counting is not applied.
- States are implicit (PROG / COUNT selected by enablen; COUNT splits into RUNNING / AT_ZERO by zero). No other FSM.

Decomposition:
- Shared header timer_defs: DIGIT_MAX, SEC_TENS_MAX, BCD digit width 4.
- One natural sub-module, bcd_down_digit: 4-bit digit register with load, shift-in, decrement and borrow-out, parameterised wrap value.
- Four bcd_down_digit instances are chained by borrow. sec_tens uses wrap SEC_TENS_MAX; the others use DIGIT_MAX.

Test Plan:
- Reset: with pgt_1Hz=1 and loadn=0 during clear, deassert clear -> digits 0000, zero=1, done=0, no shift or tick in the first cycle.
- Key entry: enablen=1; strobe D=1,2,3,0 with one loadn low pulse each (held 5 cycles) -> after each strobe 0001, 0012, 0123, 1230. D=11 strobe -> unchanged 1230.
- Countdown borrow: load 0100; enablen=0; 1 tick -> 0059; further tick -> 0058. Load 1000, 1 tick -> 0959.
- Terminal: from 0002, 2 ticks -> 0001 then 0000. done is high for exactly one cycle, zero=1. Further ticks -> stay 0000, done stays 0.
- Mode guards: counting mode with loadn strobes -> no digit change; programming mode with ticks -> no decrement; switch modes mid-count at 0730 -> 0730 retained.
- Clear mid-count at 0415 -> next cycle 0000, done=0.

Source files
------------

// File: rtl/microwave_timer_core_pkg.sv
// Shared definitions for the microwave MM:SS countdown timer.
package microwave_timer_core_pkg;

    localparam int DIGIT_W      = 4;
    localparam int DIGIT_MAX    = 9;
    localparam int SEC_TENS_MAX = 5;

    typedef logic [DIGIT_W-1:0] bcd_t;

    function automatic logic digit_ok(input bcd_t d, input bcd_t max_code);
        return d <= max_code;
    endfunction

endpackage

// File: rtl/microwave_timer_core_if.sv
// Key/timebase inputs and BCD display outputs of the timer core.
interface microwave_timer_core_if;
    import microwave_timer_core_pkg::*;

    logic enablen;
    bcd_t D;
    logic loadn;
    logic pgt_1Hz;
    bcd_t min_tens;
    bcd_t min_ones;
    bcd_t sec_tens;
    bcd_t sec_ones;
    logic zero;
    logic done;

    modport master (
        output enablen, D, loadn, pgt_1Hz,
        input  min_tens, min_ones, sec_tens, sec_ones, zero, done
    );

    modport slave (
        input  enablen, D, loadn, pgt_1Hz,
        output min_tens, min_ones, sec_tens, sec_ones, zero, done
    );
endinterface

// File: rtl/microwave_timer_core_bcd_down_digit.sv
// One BCD digit: shift-in load, decrement with wrap, borrow out when at 0.
module bcd_down_digit
    import microwave_timer_core_pkg::*;
#(
    parameter int WRAP = DIGIT_MAX
) (
    input  logic clk,
    input  logic clear,
    input  logic shift_en,
    input  bcd_t shift_in,
    input  logic borrow_in,
    output bcd_t q,
    output logic borrow_out
);
    localparam bcd_t WRAP_V = bcd_t'(WRAP);

    bcd_t q_d, q_q;

    always_comb begin
        q_d = q_q;
        if (shift_en) begin
            q_d = shift_in;
        end else if (borrow_in) begin
            q_d = (q_q == '0) ? WRAP_V : q_q - bcd_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clear) q_q <= '0;
        else       q_q <= q_d;
    end

    assign q          = q_q;
    assign borrow_out = borrow_in & (q_q == '0);
endmodule

// File: rtl/microwave_timer_core.sv
// Four-digit BCD MM:SS timer: key entry shifts digits left, 1 Hz ticks count down.
module microwave_timer_core
    import microwave_timer_core_pkg::*;
#(
    parameter int SEC_TENS_MAX_P = SEC_TENS_MAX,
    parameter int DIGIT_MAX_P    = DIGIT_MAX
) (
    input  logic                   clk,
    input  logic                   clear,
    microwave_timer_core_if.slave  tif
);
    localparam bcd_t DMAX = bcd_t'(DIGIT_MAX_P);

    logic loadn_d, loadn_q;
    logic pgt_d, pgt_q;
    logic done_d, done_q;
    logic load_ev, tick_ev, shift_en, dec_en, zero;
    logic b_so, b_st, b_mo, b_mt;
    bcd_t mt, mo, st, so;

    // Edge registers track their inputs in both modes so a mode switch never fakes an edge.
    always_comb begin
        loadn_d  = tif.loadn;
        pgt_d    = tif.pgt_1Hz;
        load_ev  = loadn_q & ~tif.loadn;
        tick_ev  = ~pgt_q & tif.pgt_1Hz;
        zero     = (mt == '0) && (mo == '0) && (st == '0) && (so == '0);
        shift_en = tif.enablen & load_ev & digit_ok(tif.D, DMAX);
        dec_en   = ~tif.enablen & tick_ev & ~zero;
        done_d   = dec_en && (mt == '0) && (mo == '0) && (st == '0) && (so == bcd_t'(1));
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            loadn_q <= 1'b1;
            pgt_q   <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            loadn_q <= loadn_d;
            pgt_q   <= pgt_d;
            done_q  <= done_d;
        end
    end

    bcd_down_digit #(.WRAP(DIGIT_MAX_P)) u_sec_ones (
        .clk(clk), .clear(clear), .shift_en(shift_en), .shift_in(tif.D),
        .borrow_in(dec_en), .q(so), .borrow_out(b_so)
    );

    bcd_down_digit #(.WRAP(SEC_TENS_MAX_P)) u_sec_tens (
        .clk(clk), .clear(clear), .shift_en(shift_en), .shift_in(so),
        .borrow_in(b_so), .q(st), .borrow_out(b_st)
    );

    bcd_down_digit #(.WRAP(DIGIT_MAX_P)) u_min_ones (
        .clk(clk), .clear(clear), .shift_en(shift_en), .shift_in(st),
        .borrow_in(b_st), .q(mo), .borrow_out(b_mo)
    );

    bcd_down_digit #(.WRAP(DIGIT_MAX_P)) u_min_tens (
        .clk(clk), .clear(clear), .shift_en(shift_en), .shift_in(mo),
        .borrow_in(b_mo), .q(mt), .borrow_out(b_mt)
    );

    assign tif.min_tens = mt;
    assign tif.min_ones = mo;
    assign tif.sec_tens = st;
    assign tif.sec_ones = so;
    assign tif.zero     = zero;
    assign tif.done     = done_q;
endmodule

// File: tb/tb_microwave_timer_core.sv
// Bench for microwave_timer_core: vector tables, corner sequences and random stimulus vs a minutes/seconds model.
module tb_microwave_timer_core;

    logic clk = 1'b0;
    logic clear;
    always #5 clk = ~clk;

    microwave_timer_core_if tif();

    microwave_timer_core dut (
        .clk   (clk),
        .clear (clear),
        .tif   (tif.slave)
    );

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    string phase = "init";

    // Model state: minutes and seconds as plain integers, plus the previous input levels.
    int m_mm = 0, m_ss = 0;
    bit m_done = 0;
    bit m_pl = 1, m_pp = 1;

    typedef struct {
        logic [3:0]  d;
        logic [15:0] exp;
    } key_vec_t;

    typedef struct {
        logic [15:0] start;
        int          nticks;
        logic [15:0] exp;
    } tick_vec_t;

    function automatic logic [15:0] dut_bcd();
        return {tif.min_tens, tif.min_ones, tif.sec_tens, tif.sec_ones};
    endfunction

    function automatic logic [15:0] model_bcd();
        return {4'(m_mm / 10), 4'(m_mm % 10), 4'(m_ss / 10), 4'(m_ss % 10)};
    endfunction

    task automatic step();
        int n;
        bit le, te;
        logic exp_zero;
        if (clear) begin
            m_mm = 0; m_ss = 0; m_done = 0; m_pl = 1; m_pp = 1;
        end else begin
            le = m_pl && !tif.loadn;
            te = !m_pp && tif.pgt_1Hz;
            m_done = 0;
            if (tif.enablen) begin
                if (le && tif.D <= 4'd9) begin
                    n = ((m_mm * 100 + m_ss) * 10 + int'(tif.D)) % 10000;
                    m_mm = n / 100;
                    m_ss = n % 100;
                end
            end else if (te && (m_mm != 0 || m_ss != 0)) begin
                if (m_ss > 0) m_ss = m_ss - 1;
                else begin m_ss = 59; m_mm = m_mm - 1; end
                m_done = (m_mm == 0 && m_ss == 0);
            end
            m_pl = tif.loadn;
            m_pp = tif.pgt_1Hz;
        end
        @(posedge clk);
        #1;
        exp_zero = (m_mm == 0 && m_ss == 0);
        if (tif.done) done_cnt++;
        checks++;
        if ({dut_bcd(), tif.zero, tif.done} !== {model_bcd(), exp_zero, m_done}) begin
            errors++;
            $display("FAIL model[%s] got %h zero=%b done=%b expected %h zero=%b done=%b",
                     phase, dut_bcd(), tif.zero, tif.done, model_bcd(), exp_zero, m_done);
        end
        @(negedge clk);
    endtask

    task automatic expect_bcd(input string name, input logic [15:0] exp);
        checks++;
        if (dut_bcd() !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, dut_bcd(), exp);
        end
    endtask

    task automatic expect_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic key_in(input logic [3:0] d);
        tif.D = d;
        tif.loadn = 1'b0;
        repeat (5) step();
        tif.loadn = 1'b1;
        repeat (2) step();
    endtask

    task automatic tick_once();
        tif.pgt_1Hz = 1'b1;
        repeat (2) step();
        tif.pgt_1Hz = 1'b0;
        repeat (2) step();
    endtask

    task automatic load_value(input logic [15:0] v);
        tif.enablen = 1'b1;
        for (int i = 3; i >= 0; i--) key_in(v[i*4 +: 4]);
    endtask

    key_vec_t  key_tbl[5];
    tick_vec_t tick_tbl[8];

    initial begin
        key_tbl[0] = '{4'd1,  16'h0001};
        key_tbl[1] = '{4'd2,  16'h0012};
        key_tbl[2] = '{4'd3,  16'h0123};
        key_tbl[3] = '{4'd0,  16'h1230};
        key_tbl[4] = '{4'd11, 16'h1230};

        tick_tbl[0] = '{16'h0100, 1, 16'h0059};
        tick_tbl[1] = '{16'h0100, 2, 16'h0058};
        tick_tbl[2] = '{16'h1000, 1, 16'h0959};
        tick_tbl[3] = '{16'h0002, 1, 16'h0001};
        tick_tbl[4] = '{16'h0002, 2, 16'h0000};
        tick_tbl[5] = '{16'h0000, 3, 16'h0000};
        tick_tbl[6] = '{16'h0099, 1, 16'h0098};
        tick_tbl[7] = '{16'h0990, 1, 16'h0989};

        // Reset with loadn low and the timebase already high.
        phase = "reset";
        clear = 1'b1;
        tif.enablen = 1'b1;
        tif.D = 4'd5;
        tif.loadn = 1'b0;
        tif.pgt_1Hz = 1'b1;
        repeat (3) step();
        expect_bcd("reset_digits", 16'h0000);
        expect_int("reset_zero", int'(tif.zero), 1);
        expect_int("reset_done", int'(tif.done), 0);
        clear = 1'b0;
        tif.loadn = 1'b1;
        tif.enablen = 1'b0;
        step();
        expect_bcd("post_reset_first_cycle", 16'h0000);
        tif.pgt_1Hz = 1'b0;
        step();

        phase = "keys";
        tif.enablen = 1'b1;
        foreach (key_tbl[i]) begin
            key_in(key_tbl[i].d);
            expect_bcd($sformatf("key_%0d", i), key_tbl[i].exp);
        end

        phase = "ticks";
        foreach (tick_tbl[i]) begin
            clear = 1'b1; step(); clear = 1'b0;
            load_value(tick_tbl[i].start);
            tif.enablen = 1'b0;
            step();
            repeat (tick_tbl[i].nticks) tick_once();
            expect_bcd($sformatf("count_%0d", i), tick_tbl[i].exp);
        end

        phase = "terminal";
        load_value(16'h0002);
        tif.enablen = 1'b0;
        step();
        tick_once();
        expect_bcd("term_one", 16'h0001);
        done_cnt = 0;
        tick_once();
        expect_bcd("term_zero", 16'h0000);
        expect_int("term_done_pulses", done_cnt, 1);
        expect_int("term_zero_flag", int'(tif.zero), 1);
        done_cnt = 0;
        repeat (2) tick_once();
        expect_bcd("term_hold", 16'h0000);
        expect_int("term_no_more_done", done_cnt, 0);

        phase = "guards";
        load_value(16'h0731);
        tif.enablen = 1'b0;
        step();
        tick_once();
        expect_bcd("guard_count", 16'h0730);
        key_in(4'd4);
        expect_bcd("guard_keys_in_count", 16'h0730);
        tif.enablen = 1'b1;
        repeat (3) step();
        expect_bcd("guard_switch_retained", 16'h0730);
        tick_once();
        expect_bcd("guard_ticks_in_prog", 16'h0730);
        tif.D = 4'd3;
        tif.loadn = 1'b0;
        tif.enablen = 1'b0;
        repeat (3) step();
        tif.loadn = 1'b1;
        step();
        expect_bcd("guard_coincident_switch", 16'h0730);
        tick_once();
        expect_bcd("guard_resume", 16'h0729);

        phase = "clear_mid";
        load_value(16'h0416);
        tif.enablen = 1'b0;
        step();
        tick_once();
        expect_bcd("clear_pre", 16'h0415);
        clear = 1'b1;
        tif.pgt_1Hz = 1'b1;
        step();
        expect_bcd("clear_digits", 16'h0000);
        expect_int("clear_done", int'(tif.done), 0);
        clear = 1'b0;
        step();

        phase = "random";
        for (int c = 0; c < 3000; c++) begin
            clear = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 29) == 0) tif.enablen = ~tif.enablen;
            if ($urandom_range(0, 2) == 0) tif.loadn = ~tif.loadn;
            if ($urandom_range(0, 2) == 0) tif.pgt_1Hz = ~tif.pgt_1Hz;
            tif.D = 4'($urandom_range(0, 15));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
